// File: rtl/ahb_master.sv
// ahb_master: one-command-at-a-time AHB-Lite master engine.
// Turns valid/ready/delay commands into NONSEQ/SEQ/BUSY address phases, data phases and read returns.
module ahb_master #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    output logic                      ready,
    input  logic                      delay,
    input  logic                      write,
    input  logic [AHB_ADDR_WIDTH-1:0] addr,
    input  logic [2:0]                burst,
    input  logic [3:0]                size,
    input  logic [AHB_DATA_WIDTH-1:0] wdata,
    output logic [AHB_DATA_WIDTH-1:0] rdata,
    output logic                      rvalid,
    output logic                      master_error,
    output logic                      other_error,
    output logic [AHB_ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic [AHB_DATA_WIDTH-1:0] HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP
);
    localparam int AW       = AHB_ADDR_WIDTH;
    localparam int DW       = AHB_DATA_WIDTH;
    localparam int MAX_SIZE = $clog2(DW / 8);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;

    function automatic logic [4:0] burst_beats(input logic [2:0] b);
        case (b)
            3'b010, 3'b011: burst_beats = 5'd4;
            3'b100, 3'b101: burst_beats = 5'd8;
            3'b110, 3'b111: burst_beats = 5'd16;
            default:        burst_beats = 5'd1;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [2:0]      hsize_q, hsize_d;
    logic [2:0]      hburst_q, hburst_d;
    logic [DW-1:0]   hwdata_q, hwdata_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            dphase_q, dphase_d;
    logic            dwrite_q, dwrite_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            merr_q, merr_d;
    logic            oerr_q, oerr_d;

    logic [AW-1:0]   align_mask, inc, wrap_mask, addr_inc, addr_next;
    logic [15:0]     span;
    logic            fixed_incr, illegal, is_wrap, undef_len, cross_1k;
    logic            accept, hold_off, last_beat;

    // Command legality: size, alignment, and 1 KB crossing of fixed-length INCR bursts.
    assign fixed_incr = burst[0] && (burst != 3'b001);
    assign align_mask = (AW'(1) << size) - AW'(1);
    assign span       = {6'd0, addr[9:0]} + (16'(burst_beats(burst)) << size);
    assign illegal    = (size > 4'(MAX_SIZE)) || (|(addr & align_mask))
                        || (fixed_incr && (span > 16'd1024));

    assign is_wrap   = !hburst_q[0] && (hburst_q != 3'b000);
    assign undef_len = (hburst_q == 3'b001);
    assign inc       = AW'(1) << hsize_q;
    assign wrap_mask = (AW'(burst_beats(hburst_q)) << hsize_q) - AW'(1);
    assign addr_inc  = haddr_q + inc;
    assign addr_next = is_wrap ? ((haddr_q & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
    assign cross_1k  = addr_next[AW-1:10] != haddr_q[AW-1:10];

    assign accept    = ((htrans_q == T_NONSEQ) || (htrans_q == T_SEQ)) && HREADY;
    // A dropped valid stalls a fixed-length burst but terminates an undefined-length one.
    assign hold_off  = delay || (!valid && !undef_len);
    assign last_beat = undef_len ? !valid : (cnt_q == 5'd1);

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hburst_d = hburst_q;
        hwdata_d = hwdata_q;
        cnt_d    = cnt_q;
        dphase_d = dphase_q;
        dwrite_d = dwrite_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        merr_d   = 1'b0;
        oerr_d   = 1'b0;

        if (dphase_q && HREADY) begin
            dphase_d = 1'b0;
            if (!HRESP && !dwrite_q) begin
                rdata_d  = HRDATA;
                rvalid_d = 1'b1;
            end
        end
        if (accept) begin
            hwdata_d = wdata;
            dphase_d = 1'b1;
            dwrite_d = hwrite_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (valid && !delay) begin
                    if (illegal) begin
                        oerr_d = 1'b1;
                    end else begin
                        haddr_d  = addr;
                        htrans_d = T_NONSEQ;
                        hwrite_d = write;
                        hsize_d  = size[2:0];
                        hburst_d = burst;
                        cnt_d    = burst_beats(burst);
                        state_d  = S_ADDR;
                    end
                end
            end
            S_ADDR, S_BURST: begin
                if (accept) begin
                    cnt_d = cnt_q - 5'd1;
                    if (last_beat) begin
                        htrans_d = T_IDLE;
                        state_d  = S_LAST;
                    end else begin
                        haddr_d = addr_next;
                        if (undef_len && cross_1k) begin
                            htrans_d = T_NONSEQ;
                            state_d  = S_ADDR;
                        end else begin
                            htrans_d = hold_off ? T_BUSY : T_SEQ;
                            state_d  = S_BURST;
                        end
                    end
                end else if ((htrans_q == T_BUSY) && HREADY && !hold_off) begin
                    htrans_d = T_SEQ;
                end
            end
            S_LAST: begin
                if (HREADY) state_d = S_IDLE;
            end
            S_ERR: begin
                if (HREADY) begin
                    merr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An error response cancels any pending address and aborts the rest of the burst.
        if ((state_q == S_ADDR || state_q == S_BURST || state_q == S_LAST) && dphase_q && HRESP) begin
            htrans_d = T_IDLE;
            dphase_d = 1'b0;
            if (HREADY) begin
                merr_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                dphase_d = 1'b1;
                state_d  = S_ERR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            htrans_q <= T_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hwdata_q <= '0;
            cnt_q    <= '0;
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            merr_q   <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hburst_q <= hburst_d;
            hwdata_q <= hwdata_d;
            cnt_q    <= cnt_d;
            dphase_q <= dphase_d;
            dwrite_q <= dwrite_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            merr_q   <= merr_d;
            oerr_q   <= oerr_d;
        end
    end

    assign ready        = accept;
    assign HADDR        = haddr_q;
    assign HTRANS       = htrans_q;
    assign HWRITE       = hwrite_q;
    assign HSIZE        = hsize_q;
    assign HBURST       = hburst_q;
    assign HWDATA       = hwdata_q;
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign master_error = merr_q;
    assign other_error  = oerr_q;
endmodule

// File: doc/ahb_master.md
# ahb_master

Protocol engine between the testbench-facing master command port (`valid`/`ready`/`delay` handshake) and the AHB-Lite bus. Takes one command at a time (single or burst, read or write), drives NONSEQ/SEQ/BUSY/IDLE address phases and write data phases, returns read data, and reports bus errors (`master_error`) and illegal commands (`other_error`). Sits directly downstream of the master command interface and upstream of the AHB interconnect/slave.

## Interface
- `AHB_ADDR_WIDTH`, 32, address width
- `AHB_DATA_WIDTH`, 32, data width (32/64/128)
- `clk`  in  1  bus clock (HCLK)
- `rst`  in  1  asynchronous, active-high reset
- `valid`  in  1  command/beat valid
- `ready`  out  1  beat accepted (combinational: address phase accepted this cycle)
- `delay`  in  1  insert BUSY instead of the next SEQ; blocks new command acceptance
- `write`, `addr`, `burst[2:0]`, `size[3:0]`  in  1/ADDR/3/4  command fields, sampled at command acceptance
- `wdata`  in  DATA  write data for the current beat, sampled when `ready`=1
- `rdata`  out  DATA  read data, valid when `rvalid`=1
- `rvalid`  out  1  one-cycle pulse per completed read beat
- `master_error`  out  1  one-cycle pulse on HRESP error
- `other_error`  out  1  one-cycle pulse on an illegal command
- `HADDR`, `HTRANS[1:0]`, `HWRITE`, `HSIZE[2:0]`, `HBURST[2:0]`, `HWDATA`  out  AHB master outputs (registered)
- `HRDATA`, `HREADY`, `HRESP`  in  AHB slave responses

## Operation
- States: IDLE, ADDR (NONSEQ), BURST (SEQ/BUSY), LAST (final data phase only), ERR.
- IDLE: at an edge with `valid`=1, `delay`=0: legality check. Illegal -> `other_error` pulses the next cycle, no bus activity, stay IDLE. Legal -> latch fields, go ADDR.
- Illegal: `size` > log2(DATA/8); `addr` not aligned to `1<<size`; fixed-length INCR4/8/16 crossing a 1 KB boundary.
- Beats: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16; INCR (1) is undefined length — continues while `valid`=1 at each beat boundary; ends at the first boundary where `valid`=0.
- `ready` = (HTRANS is NONSEQ or SEQ) && HREADY; at that edge `wdata` is captured into the HWDATA register; beat counter decrements.
- Next address: increment by `1<<size`; WRAPn: boundary B = n<<size, next = (addr & ~(B-1)) | ((addr + inc) & (B-1)).
- INCR crossing 1 KB: next beat is issued as NONSEQ, not SEQ.
- In BURST, `delay`=1 -> HTRANS=BUSY holding the next address/controls; no beat is accepted. BUSY is never issued after the last beat or on SINGLE.
- Last beat accepted -> LAST: HTRANS=IDLE; on completion -> IDLE. A new command is accepted in IDLE no earlier than the cycle after LAST completes.
- Read data phase complete (HREADY=1, HRESP=0): `rdata`<=HRDATA, `rvalid`=1 next cycle.
- Error: HRESP=1 & HREADY=0 -> HTRANS=IDLE next cycle (pending address cancelled), ERR. HRESP=1 & HREADY=1 -> `master_error` pulses, burst aborted, -> IDLE. There is no `rvalid` for the failed beat. User drops `valid` after `master_error`.

## Timing
- Reset (async): state IDLE; `HTRANS`=IDLE, `HADDR`/`HWRITE`/`HSIZE`/`HBURST`/`HWDATA`=0, `ready`/`rvalid`/`rdata`/`master_error`/`other_error`=0. Reset mid-burst abandons the burst with no further bus activity.
- Command accepted at edge T -> NONSEQ on HADDR/HTRANS in T+1; `ready` in T+1 if HREADY=1.
- Zero-wait burst of N beats: N consecutive `ready` cycles, T+1..T+N; write data for beat k on HWDATA in cycle T+1+k.
- HREADY=0: all H* outputs held, `ready`=0, BUSY/SEQ decisions frozen.
- `delay` sampled per cycle in BURST; it takes effect on the next registered HTRANS.
- `rvalid` lags HREADY completion by one cycle.
- `valid` drop in fixed-length burst mid-beat: counts as `delay` (BUSY), not termination.

## Test plan
- SINGLE write, addr 0x100, size 2, wdata 0xDEADBEEF, HREADY=1 -> NONSEQ@0x100 one cycle, HWDATA=0xDEADBEEF next cycle, one `ready`, return to IDLE.
- WRAP4 read, addr 0x38, size 2 -> HADDR 0x38,0x3C,0x30,0x34 (NONSEQ,SEQ,SEQ,SEQ), 4 `rvalid` pulses with HRDATA values in order.
- INCR8 write, 2 HREADY wait states on beat 3 and `delay`=1 for 1 cycle after beat 5 -> outputs held during waits, one BUSY cycle, 8 `ready` pulses, correct HWDATA order.
- Error on beat 2 of INCR4: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS=IDLE in second error cycle, one `master_error` pulse, beats 3-4 never issued.
- Illegal commands: size 3 with AHB_DATA_WIDTH=32; addr 0x102 with size 2; INCR16 at 0x3F0 with size 2 -> `other_error` pulse, HTRANS stays IDLE.
- Undefined INCR from 0x3F8, size 2, `valid` held 4 beats -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ; `rst` asserted mid-burst -> all outputs at reset values immediately.
